// File: rtl/pmoda_rp_pin_arbiter_if.sv
// pmoda_rp_pin_arbiter_if: request/grant and pin bus between the two IOPs and the PMODA pin arbiter
interface pmoda_rp_pin_arbiter_if #(parameter int NPINS = 8);
  logic req_pmod, req_rp, grant_pmod, grant_rp, pin_sel_rp, busy;
  logic [NPINS-1:0] pmod_data_out, pmod_tri_out, rp_data_out, rp_tri_out, pin_data_out, pin_tri_out;
  modport master (
    output req_pmod, req_rp, pmod_data_out, pmod_tri_out, rp_data_out, rp_tri_out,
    input  grant_pmod, grant_rp, pin_data_out, pin_tri_out, pin_sel_rp, busy
  );
  modport slave (
    input  req_pmod, req_rp, pmod_data_out, pmod_tri_out, rp_data_out, rp_tri_out,
    output grant_pmod, grant_rp, pin_data_out, pin_tri_out, pin_sel_rp, busy
  );
endinterface

// File: rtl/pmoda_rp_pin_arbiter.sv
// pmoda_rp_pin_arbiter: request/grant owner of the PMODA pins with a tri-state guard between owners.
// Define PMODA_ARB_PREEMPT_EN to let an RP request preempt a PMOD owner.
module pmoda_rp_pin_arbiter #(
  parameter int NPINS        = 8,
  parameter int GUARD_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  pmoda_rp_pin_arbiter_if.slave bus
);
`ifdef PMODA_ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, OWN_PMOD, OWN_RP, GUARD} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic last_rp_q, last_rp_d, preempt_q, preempt_d, any_req, win_rp;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rp_d = last_rp_q;
    preempt_d = preempt_q;
    any_req   = bus.req_pmod | bus.req_rp;
    // a preempting RP request beats round-robin at guard exit
    win_rp    = bus.req_rp & (~bus.req_pmod | preempt_q | ~last_rp_q);
    case (state_q)
      IDLE: if (any_req) begin
        state_d   = win_rp ? OWN_RP : OWN_PMOD;
        last_rp_d = win_rp;
      end
      OWN_PMOD: if (!bus.req_pmod || (PREEMPT && bus.req_rp)) begin
        state_d   = GUARD;
        cnt_d     = 8'(GUARD_CYCLES - 1);
        preempt_d = PREEMPT & bus.req_rp;
      end
      OWN_RP: if (!bus.req_rp) begin
        state_d = GUARD;
        cnt_d   = 8'(GUARD_CYCLES - 1);
      end
      default: if (cnt_q == 8'd0) begin
        state_d   = !any_req ? IDLE : win_rp ? OWN_RP : OWN_PMOD;
        last_rp_d = any_req ? win_rp : last_rp_q;
        preempt_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      last_rp_q <= 1'b1;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rp_q <= last_rp_d;
      preempt_q <= preempt_d;
    end
  end
  assign bus.grant_pmod   = state_q == OWN_PMOD;
  assign bus.grant_rp     = state_q == OWN_RP;
  assign bus.pin_sel_rp   = state_q == OWN_RP;
  assign bus.busy         = state_q == GUARD;
  assign bus.pin_data_out = state_q == OWN_PMOD ? bus.pmod_data_out :
                            state_q == OWN_RP   ? bus.rp_data_out   : {NPINS{1'b0}};
  assign bus.pin_tri_out  = state_q == OWN_PMOD ? bus.pmod_tri_out :
                            state_q == OWN_RP   ? bus.rp_tri_out   : {NPINS{1'b1}};
endmodule

// File: tb/tb_pmoda_rp_pin_arbiter.sv
// tb_pmoda_rp_pin_arbiter: directed and random checks of the PMODA pin arbiter against an ownership model.
module tb_pmoda_rp_pin_arbiter;
  localparam int N = 8;
  localparam int G = 4;
`ifdef PMODA_ARB_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fails = 0;
  int owner = 0;
  int guard_left = 0;
  bit last_rp = 1'b1;
  bit rp_priority = 1'b0;
  always #5 clk = ~clk;
  pmoda_rp_pin_arbiter_if #(.NPINS(N)) bus ();
  pmoda_rp_pin_arbiter #(.NPINS(N), .GUARD_CYCLES(G)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic give(input bit p, input bit r);
    bit to_rp;
    to_rp = r && (!p || rp_priority || !last_rp);
    owner = (p || r) ? (to_rp ? 2 : 1) : 0;
    if (p || r) last_rp = to_rp;
    rp_priority = 1'b0;
  endtask
  task automatic model(input bit rst, input bit p, input bit r);
    if (rst) begin
      owner = 0; guard_left = 0; last_rp = 1'b1; rp_priority = 1'b0;
    end else if (guard_left > 0) begin
      guard_left--;
      if (guard_left == 0) give(p, r);
    end else if (owner == 0) begin
      give(p, r);
    end else if ((owner == 1 && (!p || (PRE && r))) || (owner == 2 && !r)) begin
      rp_priority = owner == 1 && PRE && r;
      owner = 0;
      guard_left = G;
    end
  endtask
  task automatic compare();
    logic [N-1:0] etri, edata;
    etri  = owner == 1 ? bus.pmod_tri_out  : owner == 2 ? bus.rp_tri_out  : 8'hFF;
    edata = owner == 1 ? bus.pmod_data_out : owner == 2 ? bus.rp_data_out : 8'h00;
    check("grant_pmod", bus.grant_pmod, owner == 1);
    check("grant_rp", bus.grant_rp, owner == 2);
    check("pin_sel_rp", bus.pin_sel_rp, owner == 2);
    check("busy", bus.busy, guard_left > 0);
    check("pin_tri", bus.pin_tri_out, etri);
    check("pin_data", bus.pin_data_out, edata);
    check("no_double_grant", bus.grant_pmod && bus.grant_rp, 1'b0);
    if (!bus.grant_pmod && !bus.grant_rp) check("released_tri", bus.pin_tri_out, 8'hFF);
  endtask
  task automatic cycle();
    @(posedge clk);
    model(reset, bus.req_pmod, bus.req_rp);
    #1;
    compare();
  endtask
  initial begin
    bus.req_pmod = 1'b0; bus.req_rp = 1'b0;
    bus.pmod_data_out = 8'h3C; bus.pmod_tri_out = 8'h0F;
    bus.rp_data_out = 8'hA5; bus.rp_tri_out = 8'h00;
    cycle(); cycle();
    check("rst_tri", bus.pin_tri_out, 8'hFF);
    check("rst_data", bus.pin_data_out, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    bus.req_pmod = 1'b1;
    cycle();
    check("t1_grant_pmod", bus.grant_pmod, 1'b1);
    check("t1_pin_data", bus.pin_data_out, 8'h3C);
    check("t1_pin_tri", bus.pin_tri_out, 8'h0F);
    check("t1_sel", bus.pin_sel_rp, 1'b0);
    bus.req_pmod = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0; bus.req_pmod = 1'b1; bus.req_rp = 1'b1;
    cycle();
    check("t2_first_pmod", bus.grant_pmod, 1'b1);
    bus.req_pmod = 1'b0;
    for (int i = 0; i < G; i++) begin
      cycle();
      check("t2_guard_busy", bus.busy, 1'b1);
      check("t2_guard_tri", bus.pin_tri_out, 8'hFF);
    end
    cycle();
    check("t2_grant_rp", bus.grant_rp, 1'b1);
    check("t2_sel_rp", bus.pin_sel_rp, 1'b1);
    check("t3_rp_data", bus.pin_data_out, 8'hA5);
    check("t3_rp_tri", bus.pin_tri_out, 8'h00);
    bus.req_rp = 1'b0;
    for (int i = 0; i < G; i++) begin
      cycle();
      check("t3_guard_tri", bus.pin_tri_out, 8'hFF);
      check("t3_guard_data", bus.pin_data_out, 8'h00);
    end
    cycle();
    check("t3_idle_busy", bus.busy, 1'b0);
    check("t3_idle_grant", bus.grant_rp, 1'b0);
    bus.req_pmod = 1'b1;
    cycle();
    bus.req_pmod = 1'b0;
    cycle(); cycle();
    check("t4_in_guard", bus.busy, 1'b1);
    reset = 1'b1;
    cycle();
    check("t4_rst_busy", bus.busy, 1'b0);
    check("t4_rst_grant", bus.grant_pmod | bus.grant_rp, 1'b0);
    check("t4_rst_tri", bus.pin_tri_out, 8'hFF);
    reset = 1'b0; bus.req_pmod = 1'b1;
    cycle();
    bus.req_rp = 1'b1;
    cycle();
    bus.req_rp = 1'b0;
    repeat (G + 2) cycle();
    check("t5_pmod_back", bus.grant_pmod, 1'b1);
    bus.req_rp = 1'b1;
    cycle();
    check("t5_preempt_busy", bus.busy, PRE);
    repeat (G) cycle();
    check("t5_grant_rp", bus.grant_rp, PRE);
    check("t5_grant_pmod", bus.grant_pmod, !PRE);
    bus.req_rp = 1'b0;
    repeat (G + 1) cycle();
    check("t5_pmod_regrant", bus.grant_pmod, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) bus.req_pmod = ~bus.req_pmod;
      if ($urandom_range(0, 5) == 0) bus.req_rp = ~bus.req_rp;
      bus.pmod_data_out = N'($urandom); bus.pmod_tri_out = N'($urandom);
      bus.rp_data_out = N'($urandom); bus.rp_tri_out = N'($urandom);
      reset = $urandom_range(0, 79) == 0;
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
